// File: rtl/apb_master_bridge_pkg.sv
// apb_master_bridge_pkg
//   Shared types and defaults for the APB master bridge.
//   - apb_state_e : bridge FSM states (IDLE, SETUP, ACCESS)
//   - APB_ADDR_W / APB_DATA_W : default bus widths (match the GPIO slave)
package apb_master_bridge_pkg;

  localparam int APB_ADDR_W = 5;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if
//   Bundles the requester port (req_*/rsp_*) and the APB master port
//   (psel/penable/pwrite/paddr/pwdata/pready/prdata).
//   modport master : the bridge's view (drives req_ready, rsp_*, APB controls)
//   modport slave  : the surrounding environment (requester + APB slave)
interface apb_master_bridge_if
  import apb_master_bridge_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, pready, prdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, pready, prdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_master_bridge_wait_timer.sv
// apb_wait_timer
//   Clear/enable counter bounding the ACCESS phase.
//   Ports: clk, rst (sync, active-low), clr (zero the count), en (count up),
//          tc (count == TIMEOUT-1; tied 0 when TIMEOUT == 0 = wait forever).
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  generate
    if (TIMEOUT == 0) begin : g_no_limit
      assign tc = 1'b0;
    end else begin : g_limit
      assign tc = (cnt_q == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Single-outstanding APB master. Takes one request on the valid/ready
//   port, runs SETUP then ACCESS, waits for pready (bounded by TIMEOUT
//   ACCESS cycles, 0 = unbounded) and returns a one-cycle rsp_valid pulse
//   with read data or rsp_err on timeout.
//   Ports: clk, rst (sync, active-low), bus (apb_master_bridge_if.master).
//   Build option: APB_WRITE_NOREADY_EN -- writes finish after one ACCESS
//   cycle without pready, for slaves that never ack writes.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  apb_master_bridge_if.master bus
);

`ifdef APB_WRITE_NOREADY_EN
  localparam bit WR_NOREADY = 1'b1;
`else
  localparam bit WR_NOREADY = 1'b0;
`endif

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic accept, in_access, done_ok, timed_out, tmr_tc;

  assign bus.req_ready = rst && (state_q == IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign in_access     = (state_q == ACCESS);

  // Timer is zeroed during SETUP so it reads 0 on the first ACCESS cycle.
  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (state_q == SETUP),
    .en  (in_access && !bus.pready),
    .tc  (tmr_tc)
  );

  // pready on the terminal-count edge is a success, so done_ok takes priority.
  assign done_ok   = bus.pready || (WR_NOREADY && pwrite_q);
  assign timed_out = tmr_tc && !bus.pready;

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          pwrite_d = bus.req_write;
          paddr_d  = bus.req_addr;
          pwdata_d = bus.req_wdata;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (done_ok || timed_out) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !done_ok;
          rsp_rdata_d = (done_ok && !pwrite_q) ? bus.prdata : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
//   Self-checking bench for apb_master_bridge (TIMEOUT = 16). Honours
//   APB_WRITE_NOREADY_EN for write expectations.
module tb_apb_master_bridge;

  localparam int TO    = 16;
  localparam int NEVER = 1000;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  apb_master_bridge_if bus ();

  apb_master_bridge #(.ADDR_W(5), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [4:0]  addr;
    logic [31:0] wdata;
    int          dly;     // ACCESS cycles with pready low before it rises
    logic [31:0] rd;
    int          exp_lat; // cycles from accept edge T to rsp_valid
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: outcome from the transfer rules, in terms of ACCESS cycles.
  function automatic void model(input logic w, input int dly, input logic [31:0] rd,
                                output int lat, output logic err, output logic [31:0] rdata);
    bit imm = 1'b0;
`ifdef APB_WRITE_NOREADY_EN
    imm = w;
`endif
    if (imm) begin
      lat = 3; err = 1'b0; rdata = '0;
    end else if (dly < TO) begin
      lat = 3 + dly; err = 1'b0; rdata = w ? 32'h0 : rd;
    end else begin
      lat = 2 + TO; err = 1'b1; rdata = '0;
    end
  endfunction

  // One transfer from IDLE; called and returns at a negedge.
  task automatic do_txn(input logic w, input logic [4:0] a, input logic [31:0] wd,
                        input int dly, input logic [31:0] rd,
                        output int lat, output logic err, output logic [31:0] rdata);
    int acc = 0;
    int bad = 0;
    lat = -1; err = 1'b0; rdata = '0;
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom); bus.req_addr = 5'($urandom); bus.req_wdata = $urandom;
    for (int k = 1; k <= 100; k++) begin
      if (bus.rsp_valid) begin
        lat = k; err = bus.rsp_err; rdata = bus.rsp_rdata;
        break;
      end
      if (k == 1 && !(bus.psel && !bus.penable)) bad++;
      if (bus.psel && (bus.paddr !== a || bus.pwrite !== w || bus.pwdata !== wd)) bad++;
      if (bus.psel && bus.penable) begin
        bus.pready = (acc == dly); bus.prdata = rd; acc++;
      end else begin
        bus.pready = 1'($urandom); bus.prdata = $urandom;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.pready = 1'b0;
    chk("apb_phase_and_stability", 32'(bad), 32'd0);
    if (lat >= 0) begin
      @(posedge clk);
      @(negedge clk);
      chk("rsp_single_cycle", 32'(bus.rsp_valid), 32'd0);
      chk("rsp_rdata_hold", bus.rsp_rdata, rdata);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat; logic err; logic [31:0] rdata;
    do_txn(v.w, v.addr, v.wdata, v.dly, v.rd, lat, err, rdata);
    chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
    chk({tag, "_rdata"}, rdata, v.exp_rdata);
  endtask

  initial begin
    int n_acc, n_rsp, last_rsp, cyc, extra;
    bit acc;

    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.pready = 1'b0; bus.prdata = '0;

    // Hand-computed vectors.
    vecs[0] = '{1'b0, 5'h03, 32'h0, 0, 32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'h1F, 32'h0, NEVER, 32'h55AA55AA, 18, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 5'h07, 32'h0, 15, 32'hCAFEF00D, 18, 1'b0, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 5'h10, 32'h0, 5, 32'h0BADF00D, 8, 1'b0, 32'h0BADF00D};
`ifdef APB_WRITE_NOREADY_EN
    vecs[2] = '{1'b1, 5'h0A, 32'h12345678, NEVER, 32'hFFFFFFFF, 3, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 5'h01, 32'hA5A5A5A5, 2, 32'hFFFFFFFF, 3, 1'b0, 32'h0};
`else
    vecs[2] = '{1'b1, 5'h0A, 32'h12345678, NEVER, 32'hFFFFFFFF, 18, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 5'h01, 32'hA5A5A5A5, 2, 32'hFFFFFFFF, 5, 1'b0, 32'h0};
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_psel", 32'(bus.psel), 32'd0);
    chk("rst_penable", 32'(bus.penable), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_paddr", 32'(bus.paddr), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Reset while in ACCESS: transfer is dropped silently.
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 5'h1F;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort_in_access", 32'({bus.psel, bus.penable}), 32'd3);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort_psel", 32'(bus.psel), 32'd0);
    chk("abort_penable", 32'(bus.penable), 32'd0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_ready_in_rst", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (bus.rsp_valid || bus.psel) extra++;
    end
    chk("abort_no_rsp", 32'(extra), 32'd0);
    chk("abort_ready_after", 32'(bus.req_ready), 32'd1);

    // Back-to-back reads 0..3, req_valid held, immediate pready.
    n_acc = 0; n_rsp = 0; last_rsp = -1; cyc = 0; extra = 0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 5'd0;
    acc = bus.req_valid && bus.req_ready;
    while (n_rsp < 4 && cyc < 100) begin
      @(posedge clk); cyc++; @(negedge clk);
      if (acc) begin
        n_acc++;
        bus.req_addr  = 5'(n_acc);
        bus.req_valid = (n_acc < 4);
      end
      if (bus.rsp_valid) begin
        chk($sformatf("b2b_rdata%0d", n_rsp), bus.rsp_rdata, 32'hA000_0000 | 32'(n_rsp));
        if (n_rsp > 0) chk($sformatf("b2b_spacing%0d", n_rsp), 32'(cyc - last_rsp), 32'd3);
        last_rsp = cyc;
        n_rsp++;
      end
      if (bus.psel && bus.paddr !== 5'(n_acc - 1)) extra++;
      bus.pready = bus.psel && bus.penable;
      bus.prdata = 32'hA000_0000 | 32'(n_acc - 1);
      acc = bus.req_valid && bus.req_ready;
    end
    bus.pready = 1'b0; bus.req_valid = 1'b0;
    chk("b2b_rsp_count", 32'(n_rsp), 32'd4);
    chk("b2b_paddr_stable", 32'(extra), 32'd0);
    @(posedge clk); @(negedge clk);

    // Randomized transfers against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic        w;
      logic [4:0]  a;
      logic [31:0] wd, rd, rdata, exp_rdata;
      int          dly, lat, exp_lat;
      logic        err, exp_err;
      w   = 1'($urandom);
      a   = 5'($urandom);
      wd  = $urandom;
      rd  = $urandom;
      dly = ($urandom_range(0, 3) == 0) ? NEVER : $urandom_range(0, 20);
      model(w, dly, rd, exp_lat, exp_err, exp_rdata);
      do_txn(w, a, wd, dly, rd, lat, err, rdata);
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(exp_lat));
      chk($sformatf("rnd%0d_err", i), 32'(err), 32'(exp_err));
      chk($sformatf("rnd%0d_rdata", i), rdata, exp_rdata);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
